// File: rtl/fp_multi_adder.sv
// rtl/fp_multi_adder.sv - sequential N-operand floating-point adder with single final rounding
module fp_multi_adder #(
   parameter int EXP_W = 5,
   parameter int MAN_W = 10,
   parameter int N_OPS = 3
) (
   input  logic                               clk,
   input  logic                               reset,
   input  logic                               start,
   input  logic [N_OPS*(1+EXP_W+MAN_W)-1:0]   operands,
   input  logic                               rnd_mode,
   input  logic                               ack,
   output logic [EXP_W+MAN_W:0]               result,
   output logic                               busy,
   output logic                               done,
   output logic                               overflow,
   output logic                               invalid
);
   localparam int FP_W = 1 + EXP_W + MAN_W;
   localparam int M    = MAN_W + 1;
   localparam int W    = MAN_W + 4;
   localparam int EW   = EXP_W + 2;
   localparam logic [3:0]           LAST_IDX = 4'(N_OPS - 1);
   localparam logic signed [EW-1:0] E_ONE    = EW'(1);
   localparam logic signed [EW-1:0] E_MAX    = EW'((1 << EXP_W) - 1);

   localparam logic [5:0] S_IDLE  = 6'b000001;
   localparam logic [5:0] S_ALIGN = 6'b000010;
   localparam logic [5:0] S_ADD   = 6'b000100;
   localparam logic [5:0] S_NORM  = 6'b001000;
   localparam logic [5:0] S_ROUND = 6'b010000;
   localparam logic [5:0] S_DONE  = 6'b100000;

   logic [5:0]              state;
   logic [N_OPS*FP_W-1:0]   ops_q;
   logic                    rnd_q;
   logic [3:0]              idx;
   logic                    acc_s;
   logic signed [EW-1:0]    acc_e;
   logic [W-1:0]            acc_m;
   logic                    pos_inf, neg_inf;
   logic                    big_s, sml_s;
   logic [W-1:0]            big_m, sml_m;
   logic signed [EW-1:0]    al_e;
   logic                    sum_s;
   logic [W:0]              sum_m;
   logic signed [EW-1:0]    sum_e;

   logic [FP_W-1:0]         op_cur;
   logic                    op_s, op_inf, op_zero, acc_zero, swap;
   logic [EXP_W-1:0]        op_ef;
   logic [W-1:0]            op_m, big_in, sml_in, aligned;
   logic signed [EW-1:0]    op_e, diff;
   int                      shamt;
   logic [2*W-1:0]          ext;

   // Accumulator mantissa layout: {hidden, fraction, guard, round, sticky}.
   always_comb begin
      op_cur   = ops_q[int'(idx) * FP_W +: FP_W];
      op_s     = op_cur[FP_W-1];
      op_ef    = op_cur[FP_W-2:MAN_W];
      op_inf   = &op_ef;
      op_zero  = (op_ef == '0) || op_inf;
      op_m     = op_zero ? '0 : {1'b1, op_cur[MAN_W-1:0], 3'b000};
      op_e     = $signed({2'b00, op_ef});
      acc_zero = (acc_m == '0);
      // A zero side never sets the exponent, so a tiny accumulator is not flushed into sticky.
      swap     = acc_zero || (!op_zero && (op_e > acc_e));
      diff     = swap ? (op_e - acc_e) : (acc_e - op_e);
      if (diff < 0)
         shamt = 0;
      else if (diff > W)
         shamt = W;
      else
         shamt = int'(diff);
      big_in  = swap ? op_m : acc_m;
      sml_in  = swap ? acc_m : op_m;
      ext     = {sml_in, {W{1'b0}}} >> shamt;
      aligned = {ext[2*W-1:W+1], ext[W] | (|ext[W-1:0])};
   end

   logic       add_s;
   logic [W:0] add_m;

   always_comb begin
      add_s = big_s;
      add_m = '0;
      if (big_s == sml_s)
         add_m = {1'b0, big_m} + {1'b0, sml_m};
      else if (big_m >= sml_m)
         add_m = {1'b0, big_m - sml_m};
      else begin
         add_m = {1'b0, sml_m - big_m};
         add_s = sml_s;
      end
      if (add_m == '0)
         add_s = 1'b0;
   end

   logic [EW-1:0]        lz;
   logic [W-1:0]         nrm_m;
   logic signed [EW-1:0] nrm_e;

   always_comb begin
      lz = '0;
      for (int k = 0; k < W; k++)
         if (sum_m[k])
            lz = EW'(W - 1 - k);
      if (sum_m[W]) begin
         nrm_m = {sum_m[W:2], sum_m[1] | sum_m[0]};
         nrm_e = sum_e + E_ONE;
      end else if (sum_m[W-1:0] == '0) begin
         nrm_m = '0;
         nrm_e = '0;
      end else begin
         nrm_m = sum_m[W-1:0] << lz;
         nrm_e = sum_e - $signed(lz);
      end
   end

   logic                 rnd_inc;
   logic [M:0]           rnd_m;
   logic [MAN_W-1:0]     rnd_f;
   logic signed [EW-1:0] rnd_e;
   logic [FP_W-1:0]      fin_res;
   logic                 fin_ovf, fin_inv;

   always_comb begin
      rnd_inc = !rnd_q && acc_m[2] && (acc_m[3] || acc_m[1] || acc_m[0]);
      rnd_m   = {1'b0, acc_m[W-1:3]} + {{M{1'b0}}, rnd_inc};
      if (rnd_m[M]) begin
         rnd_f = rnd_m[M-1:1];
         rnd_e = acc_e + E_ONE;
      end else begin
         rnd_f = rnd_m[M-2:0];
         rnd_e = acc_e;
      end
      fin_res = {acc_s, rnd_e[EXP_W-1:0], rnd_f};
      fin_ovf = 1'b0;
      fin_inv = 1'b0;
      if (pos_inf && neg_inf) begin
         fin_res = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};
         fin_inv = 1'b1;
      end else if (pos_inf || neg_inf)
         fin_res = {neg_inf, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
      else if (acc_zero || rnd_e <= 0)
         fin_res = {acc_s, {(FP_W-1){1'b0}}};
      else if (rnd_e >= E_MAX) begin
         fin_res = {acc_s, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
         fin_ovf = 1'b1;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state    <= S_IDLE;
         ops_q    <= '0;
         rnd_q    <= 1'b0;
         idx      <= '0;
         acc_s    <= 1'b0;
         acc_e    <= '0;
         acc_m    <= '0;
         pos_inf  <= 1'b0;
         neg_inf  <= 1'b0;
         big_s    <= 1'b0;
         sml_s    <= 1'b0;
         big_m    <= '0;
         sml_m    <= '0;
         al_e     <= '0;
         sum_s    <= 1'b0;
         sum_m    <= '0;
         sum_e    <= '0;
         result   <= '0;
         overflow <= 1'b0;
         invalid  <= 1'b0;
      end else begin
         case (state)
            S_IDLE: if (start) begin
               ops_q   <= operands;
               rnd_q   <= rnd_mode;
               idx     <= '0;
               acc_s   <= 1'b0;
               acc_e   <= '0;
               acc_m   <= '0;
               pos_inf <= 1'b0;
               neg_inf <= 1'b0;
               state   <= S_ALIGN;
            end
            S_ALIGN: begin
               big_s   <= swap ? op_s : acc_s;
               sml_s   <= swap ? acc_s : op_s;
               big_m   <= big_in;
               sml_m   <= aligned;
               al_e    <= swap ? op_e : acc_e;
               pos_inf <= pos_inf | (op_inf & ~op_s);
               neg_inf <= neg_inf | (op_inf & op_s);
               state   <= S_ADD;
            end
            S_ADD: begin
               sum_s <= add_s;
               sum_m <= add_m;
               sum_e <= al_e;
               state <= S_NORM;
            end
            S_NORM: begin
               acc_s <= sum_s;
               acc_m <= nrm_m;
               acc_e <= nrm_e;
               idx   <= idx + 4'd1;
               state <= (idx < LAST_IDX) ? S_ALIGN : S_ROUND;
            end
            S_ROUND: begin
               result   <= fin_res;
               overflow <= fin_ovf;
               invalid  <= fin_inv;
               state    <= S_DONE;
            end
            S_DONE: if (ack)
               state <= S_IDLE;
            default: state <= S_IDLE;
         endcase
      end
   end

   assign busy = (state != S_IDLE);
   assign done = (state == S_DONE);
endmodule

// File: tb/tb_fp_multi_adder.sv
// tb/tb_fp_multi_adder.sv - scoreboard bench for fp_multi_adder with directed FP16 vectors
module tb_fp_multi_adder;
   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        start = 1'b0;
   logic        rnd_mode = 1'b0;
   logic        ack = 1'b0;
   logic [47:0] operands = '0;
   logic [15:0] result;
   logic        busy, done, overflow, invalid;

   fp_multi_adder dut (
      .clk(clk), .reset(reset), .start(start), .operands(operands),
      .rnd_mode(rnd_mode), .ack(ack), .result(result), .busy(busy),
      .done(done), .overflow(overflow), .invalid(invalid)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [15:0] res;
      logic        ovf;
      logic        inv;
      int          due;
      string       name;
   } exp_t;

   exp_t        sb[$];
   int          total = 0;
   int          bad = 0;
   int          cyc = 0;
   logic        done_q = 1'b0;
   logic [15:0] held_res = '0;
   logic        held_ovf = 1'b0;
   logic        held_inv = 1'b0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("FAIL %s: got %h want %h", name, act, req);
      end
   endtask

   // Monitor: pops one expectation per rising done and checks the held outputs until ack.
   always @(negedge clk) begin
      if (done && !done_q) begin
         if (sb.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_done: got result %h with no pending request", result);
         end else begin
            chk({sb[0].name, "_result"}, 32'(result), 32'(sb[0].res));
            chk({sb[0].name, "_overflow"}, 32'(overflow), 32'(sb[0].ovf));
            chk({sb[0].name, "_invalid"}, 32'(invalid), 32'(sb[0].inv));
            chk({sb[0].name, "_latency"}, 32'(cyc), 32'(sb[0].due));
            void'(sb.pop_front());
         end
         held_res <= result;
         held_ovf <= overflow;
         held_inv <= invalid;
      end else if (done && done_q) begin
         chk("hold_result", 32'(result), 32'(held_res));
         chk("hold_flags", 32'({overflow, invalid}), 32'({held_ovf, held_inv}));
      end
      done_q <= done;
   end

   task automatic run(input string name, input logic [15:0] a, input logic [15:0] b,
                      input logic [15:0] c, input logic rnd, input logic [15:0] eres,
                      input logic eovf, input logic einv, input int dly,
                      input logic poke, input logic ackst);
      int n;
      @(negedge clk);
      operands = {c, b, a};
      rnd_mode = rnd;
      start    = 1'b1;
      @(posedge clk);
      #1;
      sb.push_back('{res: eres, ovf: eovf, inv: einv, due: cyc + 10, name: name});
      chk({name, "_busy"}, 32'(busy), 32'd1);
      operands = ~{c, b, a};
      rnd_mode = ~rnd;
      if (poke) begin
         operands = {16'h3C00, 16'h3C00, 16'h3C00};
         @(posedge clk);
         #1;
      end
      start = 1'b0;
      n = 0;
      while (!done && n < 50) begin
         @(negedge clk);
         n++;
      end
      if (!done) begin
         total++;
         bad++;
         $display("FAIL %s_timeout: done still %b after %0d cycles, need 1", name, done, n);
      end
      repeat (dly) @(negedge clk);
      chk({name, "_done_before_ack"}, 32'(done), 32'd1);
      @(negedge clk);
      ack = 1'b1;
      if (ackst) begin
         start    = 1'b1;
         operands = {16'h4000, 16'h4000, 16'h4000};
      end
      @(posedge clk);
      #1;
      chk({name, "_idle_after_ack"}, 32'({busy, done}), 32'd0);
      ack   = 1'b0;
      start = 1'b0;
      if (ackst) begin
         @(posedge clk);
         #1;
         chk({name, "_start_with_ack_ignored"}, 32'(busy), 32'd0);
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      repeat (3) @(negedge clk);
      chk("reset_outputs", 32'({result, busy, done, overflow, invalid}), 32'd0);
      reset = 1'b0;

      //   name          op0       op1       op2       rnd   result    ovf   inv   dly poke ackst
      run("basic",     16'h3C00, 16'h4000, 16'h3C00, 1'b0, 16'h4400, 1'b0, 1'b0, 0, 1'b0, 1'b0);
      run("cancel",    16'h3C00, 16'hBC00, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b0, 0, 1'b0, 1'b0);
      run("rne_tie",   16'h3C00, 16'h1400, 16'h1000, 1'b0, 16'h3C02, 1'b0, 1'b0, 0, 1'b0, 1'b0);
      run("trunc",     16'h3C00, 16'h1400, 16'h1000, 1'b1, 16'h3C01, 1'b0, 1'b0, 0, 1'b0, 1'b0);
      run("rnd_carry", 16'h3BFF, 16'h0C00, 16'h0000, 1'b0, 16'h3C00, 1'b0, 1'b0, 0, 1'b0, 1'b0);
      run("trunc_nc",  16'h3BFF, 16'h0C00, 16'h0000, 1'b1, 16'h3BFF, 1'b0, 1'b0, 0, 1'b0, 1'b0);
      run("mixed",     16'h4000, 16'hBC00, 16'h3800, 1'b0, 16'h3E00, 1'b0, 1'b0, 0, 1'b0, 1'b0);
      run("negative",  16'hBC00, 16'hBC00, 16'hBC00, 1'b0, 16'hC200, 1'b0, 1'b0, 0, 1'b0, 1'b0);
      run("underflow", 16'h0600, 16'h8400, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b0, 0, 1'b0, 1'b0);
      run("overflow",  16'h7BFF, 16'h7BFF, 16'h0000, 1'b0, 16'h7C00, 1'b1, 1'b0, 0, 1'b0, 1'b0);
      run("inf_prop",  16'h7C00, 16'h3C00, 16'h3C00, 1'b0, 16'h7C00, 1'b0, 1'b0, 0, 1'b0, 1'b0);
      run("start_in_align", 16'h3C00, 16'h4000, 16'h3C00, 1'b0, 16'h4400, 1'b0, 1'b0, 0, 1'b1, 1'b0);
      run("ack_late",  16'h4000, 16'h4000, 16'h3C00, 1'b0, 16'h4500, 1'b0, 1'b0, 5, 1'b0, 1'b0);
      run("ack_start", 16'h3C00, 16'h3C00, 16'h3C00, 1'b0, 16'h4200, 1'b0, 1'b0, 0, 1'b0, 1'b1);
      run("invalid",   16'h7C00, 16'hFC00, 16'h3C00, 1'b0, 16'h7E00, 1'b0, 1'b1, 0, 1'b0, 1'b0);

      // Abort a run on its fourth cycle; the held NaN and invalid flag must clear too.
      @(negedge clk);
      operands = {16'h3C00, 16'h4000, 16'h3C00};
      start    = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      repeat (3) @(posedge clk);
      #2;
      reset = 1'b1;
      #1;
      chk("midrun_reset_outputs", 32'({result, busy, done, overflow, invalid}), 32'd0);
      repeat (2) @(negedge clk);
      reset = 1'b0;
      run("after_reset", 16'h4000, 16'h4000, 16'h4000, 1'b0, 16'h4600, 1'b0, 1'b0, 0, 1'b0, 1'b0);

      repeat (15) @(negedge clk);
      chk("scoreboard_drained", 32'(sb.size()), 32'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
